debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-input debounce filter. Each channel:
- synchronises one asynchronous push-button or switch input;
- filters bounce with a consecutive-sample counter;
- emits one-cycle rise and fall pulses;
- emits a long-press pulse, either once per press or repeating.
Sits between board I/O pins and the UI/control logic. Downstream logic uses the pulses directly instead of building its own edge detectors.

---
 rtl/debounce_multi.sv | 72 +++++++
 tb/tb_debounce_multi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchroniser, consecutive-sample debounce filter,
// registered rise/fall pulses and optional long-press (hold) pulse.
module debounce_multi #(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   HOLD_LIMIT     = 0,
    parameter int   HOLD_REPEAT    = 0,
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);
    localparam int DW = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_LIMIT - 1);

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync;
            logic [DW-1:0] cnt;
            logic deb, rise, fall, hold, synced, flip;
            assign synced = sync[SYNC_STAGES-1];
            assign flip   = (synced != deb) && (cnt == DMAX);
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    sync <= {SYNC_STAGES{RESET_LEVEL}};
                    cnt  <= '0;
                    deb  <= RESET_LEVEL;
                    rise <= 1'b0;
                    fall <= 1'b0;
                end else begin
                    sync <= {sync[SYNC_STAGES-2:0], i_Bouncy[n]};
                    cnt  <= (synced == deb || flip) ? '0 : cnt + 1'b1;
                    deb  <= flip ? ~deb : deb;
                    rise <= flip && !deb;
                    fall <= flip && deb;
                end
            end
            if (HOLD_LIMIT > 0) begin : g_hold
                localparam int HW = $clog2(HOLD_LIMIT) + 1;
                localparam logic [HW-1:0] HMAX = HW'(HOLD_LIMIT);
                localparam logic [HW-1:0] HFIRE = HW'(HOLD_LIMIT - 1);
                logic [HW-1:0] hc;
                logic fire;
                // a fall accepted on the firing edge wins over the hold pulse
                assign fire = deb && (hc == HFIRE) && !flip;
                always_ff @(posedge i_Clk or posedge i_Rst) begin
                    if (i_Rst) begin
                        hc   <= '0;
                        hold <= 1'b0;
                    end else begin
                        hold <= fire;
                        hc   <= (!deb || flip || (fire && HOLD_REPEAT != 0)) ? '0 :
                                (hc == HMAX) ? hc : hc + 1'b1;
                    end
                end
            end else begin : g_nohold
                assign hold = 1'b0;
            end
            assign o_Debounced[n] = deb;
            assign o_Rise[n]      = rise;
            assign o_Fall[n]      = fall;
            assign o_Hold[n]      = hold;
        end
    endgenerate
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: two instances (hold once / hold repeat) share inputs; expected
// pulses are queued at stimulus time and checked every cycle on the falling edge.
module tb_debounce_multi;
    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_HOLD = 2;

    typedef struct {
        int e;
        int d;
        int k;
        int c;
    } ev_t;

    logic i_Clk;
    logic i_Rst;
    logic [1:0] bouncy;
    logic [1:0] o_deb[2];
    logic [1:0] o_rise[2];
    logic [1:0] o_fall[2];
    logic [1:0] o_hold[2];
    logic [1:0] ed[2];
    logic [1:0] er[2];
    logic [1:0] ef[2];
    logic [1:0] eh[2];
    ev_t q[$];
    int ecnt = 0;
    int checks = 0;
    int errors = 0;
    int a, r, base;

    debounce_multi #(
        .NUM_CH(2), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(8), .HOLD_REPEAT(0),
        .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
    ) u_dut0 (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Bouncy(bouncy),
        .o_Debounced(o_deb[0]), .o_Rise(o_rise[0]), .o_Fall(o_fall[0]), .o_Hold(o_hold[0])
    );

    debounce_multi #(
        .NUM_CH(2), .DEBOUNCE_LIMIT(4), .HOLD_LIMIT(8), .HOLD_REPEAT(1),
        .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
    ) u_dut1 (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Bouncy(bouncy),
        .o_Debounced(o_deb[1]), .o_Rise(o_rise[1]), .o_Fall(o_fall[1]), .o_Hold(o_hold[1])
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;
    always @(posedge i_Clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input int d, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d edge %0d: got %b want %b", tag, d, ecnt, got, exp);
        end
    endtask

    task automatic push(input int d, input int k, input int c, input int e);
        q.push_back('{e: e, d: d, k: k, c: c});
    endtask

    task automatic press(input int c, input int rr, input int ff);
        for (int d = 0; d < 2; d++) begin
            push(d, K_RISE, c, rr);
            push(d, K_FALL, c, ff);
        end
        if (rr + 8 < ff) push(0, K_HOLD, c, rr + 8);
        for (int t = rr + 8; t < ff; t += 8) push(1, K_HOLD, c, t);
    endtask

    task automatic wait_to(input int e);
        while (ecnt < e) @(negedge i_Clk);
    endtask

    task automatic drive_at(input logic [1:0] v, input int e);
        wait_to(e);
        bouncy = v;
    endtask

    task automatic do_reset();
        #2 i_Rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_deb", d, o_deb[d], 2'b00);
            chk("async_rst_rise", d, o_rise[d], 2'b00);
            chk("async_rst_fall", d, o_fall[d], 2'b00);
            chk("async_rst_hold", d, o_hold[d], 2'b00);
        end
        repeat (2) @(negedge i_Clk);
        #2 i_Rst = 1'b0;
    endtask

    always @(negedge i_Clk) begin
        if (i_Rst) begin
            q.delete();
            ed[0] = 2'b00;
            ed[1] = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                er[d] = 2'b00;
                ef[d] = 2'b00;
                eh[d] = 2'b00;
            end
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].e <= ecnt) begin
                    checks++;
                    assert (q[i].e == ecnt) else begin
                        errors++;
                        $error("FAIL missed kind %0d ch%0d dut%0d due edge %0d now %0d",
                               q[i].k, q[i].c, q[i].d, q[i].e, ecnt);
                    end
                    if (q[i].k == K_RISE) er[q[i].d][q[i].c] = 1'b1;
                    if (q[i].k == K_FALL) ef[q[i].d][q[i].c] = 1'b1;
                    if (q[i].k == K_HOLD) eh[q[i].d][q[i].c] = 1'b1;
                    q.delete(i);
                end
            end
            for (int d = 0; d < 2; d++) begin
                ed[d] = (ed[d] | er[d]) & ~ef[d];
                chk("deb", d, o_deb[d], ed[d]);
                chk("rise", d, o_rise[d], er[d]);
                chk("fall", d, o_fall[d], ef[d]);
                chk("hold", d, o_hold[d], eh[d]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout at edge %0d", ecnt);
        $fatal(1, "timeout");
    end

    initial begin
        i_Rst = 1'b1;
        bouncy = 2'b00;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_deb", d, o_deb[d], 2'b00);
            chk("reset_rise", d, o_rise[d], 2'b00);
            chk("reset_fall", d, o_fall[d], 2'b00);
            chk("reset_hold", d, o_hold[d], 2'b00);
        end
        repeat (3) @(negedge i_Clk);
        #2 i_Rst = 1'b0;
        repeat (10) @(negedge i_Clk);
        // clean press on ch0, held 30 cycles past the rise, then released
        a = ecnt + 1;
        drive_at(2'b01, a);
        r = a + 6;
        press(0, r, r + 36);
        drive_at(2'b00, r + 30);
        // bounce 1-0-1 then a short press released before the hold limit
        a = r + 40;
        drive_at(2'b01, a);
        drive_at(2'b00, a + 1);
        drive_at(2'b01, a + 2);
        r = a + 8;
        press(0, r, r + 7);
        drive_at(2'b00, r + 1);
        // 3-cycle glitch never accepted
        a = r + 11;
        drive_at(2'b01, a);
        drive_at(2'b00, a + 3);
        // long press on ch1 exercises hold repeat on dut1
        a = a + 13;
        drive_at(2'b10, a);
        r = a + 6;
        press(1, r, r + 36);
        drive_at(2'b00, r + 30);
        // short 5-cycle press on ch1
        a = r + 40;
        drive_at(2'b10, a);
        press(1, a + 6, a + 11);
        drive_at(2'b00, a + 5);
        // fall lands on the edge the hold would fire
        a = a + 15;
        drive_at(2'b10, a);
        r = a + 6;
        press(1, r, r + 8);
        drive_at(2'b00, r + 2);
        // ch0 rises on the same edge ch1 falls
        a = r + 12;
        drive_at(2'b10, a);
        r = a + 6;
        press(1, r, r + 7);
        drive_at(2'b01, r + 1);
        press(0, r + 7, r + 14);
        drive_at(2'b00, r + 8);
        // reset while ch0 debounce count is 2
        a = r + 20;
        drive_at(2'b01, a);
        wait_to(a + 4);
        do_reset();
        base = ecnt;
        r = base + 6;
        for (int d = 0; d < 2; d++) push(d, K_RISE, 0, r);
        // reset while hold count is 5; hold must restart from zero
        wait_to(r + 5);
        do_reset();
        base = ecnt;
        r = base + 6;
        press(0, r, r + 15);
        drive_at(2'b00, r + 9);
        wait_to(r + 25);
        @(negedge i_Clk);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL pending events: got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
